mc_alu_md: RTL and testbench
============================

# mc_alu_md

Parametrised execute-stage ALU for the multi-cycle CPU datapath. It keeps the existing operand selection (PC/regA, regB/4/sign-extended immediate/shifted immediate), single-cycle ALU ops, `zero` flag and registered `ALUOut`. It adds xor/slt, a synchronous reset, and an iterative unsigned multiply/divide engine with HI/LO registers driven by a start/busy/done handshake. It sits between the register file/IR and the ALUOut/PC-update logic; the control FSM stalls on `busy`.

## Interface
- `WIDTH`, 32, datapath width (even, ≥8)
- `IMM_W`, 16, immediate field width (< WIDTH-2)
- `clk  in  1`  clock, all state updates on rising edge
- `rst  in  1`  synchronous, active-high reset
- `ALUOp  in  2`  00 add, 01 sub, 10 decode `funct`, 11 reserved (result 0)
- `ALUSrcA  in  1`  0: A=PC, 1: A=regA
- `ALUSrcB  in  2`  00 regB, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `funct  in  6`  R-type function field
- `PC`, `regA`, `regB`  in  WIDTH  operand sources
- `IR_low16  in  IMM_W`  immediate field
- `start  in  1`  request multu/divu (with ALUOp=10, funct 011001/011011)
- `result  out  WIDTH`  combinational ALU result
- `zero  out  1`  result==0, combinational
- `ALUOut  out  WIDTH`  result registered every cycle
- `busy  out  1`  mul/div in progress
- `done  out  1`  one-cycle completion pulse
- `HI`, `LO`  out  WIDTH  mul/div result registers

## Operation
- Operand mux and sign-extension identical to current datapath; imm<<2 drops top 2 bits of the extended value.
- funct decode (ALUOp=10): 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed, result 1/0), 010000 mfhi (result=HI), 010010 mflo (result=LO); any other funct → result 0 (no latching of stale values).
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- Mul/div FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 with valid mul/div funct → latch A, B, op; counter=0; → RUN. `start` with any other funct ignored.
  - RUN: one shift-add (multu) or restoring shift-subtract (divu) step per cycle; after WIDTH steps → DONE, writing HI/LO on that edge.
  - DONE: `done`=1; → IDLE next edge.
- multu: {HI,LO} = A*B unsigned, 2·WIDTH bits.
- divu: LO = A/B, HI = A%B unsigned. B=0: LO = all ones, HI = A, same latency, no error flag.
- `start` during RUN/DONE ignored; operand inputs may change freely after the accepting edge.
- mfhi/mflo during RUN return the previous HI/LO values.

## Timing
- Reset values: ALUOut=0, HI=0, LO=0, busy=0, done=0, FSM=IDLE, counter=0. `result`/`zero` combinational from inputs and HI/LO.
- `rst` has priority over `start` and aborts RUN/DONE in the same edge; no partial HI/LO write.
- ALUOut latency: 1 cycle from inputs.
- `start` sampled at edge T → busy=1 cycles T+1..T+WIDTH, done=1 in cycle T+WIDTH+1 with HI/LO valid, busy=0 then. Earliest next accept at edge T+WIDTH+2.
- `busy` and `done` never high together.

## Configuration
- `MC_ALU_MULDIV_EN` defined: mul/div FSM, HI/LO registers, and mfhi/mflo decode present as above.
- Undefined: no FSM; `busy`=`done`=0, HI=LO=0 constantly, `start` ignored, mfhi/mflo/multu/divu funct → result 0. Single-cycle behaviour unchanged.

## Test plan
- ALUSrcA=1, ALUSrcB=10, regA=0x10, IR_low16=0xFFFC, ALUOp=00 → result=0x0C, zero=0, ALUOut=0x0C one edge later.
- ALUOp=10 funct 101010, regA=0xFFFFFFFF, regB=1 → result=1; funct 100010 with regA=regB=5 → result=0, zero=1.
- multu regA=0xFFFFFFFF, regB=2, start one cycle → busy 32 cycles, done pulse in cycle 33, HI=1, LO=0xFFFFFFFE; mflo then returns 0xFFFFFFFE.
- divu 100/7 → LO=14, HI=2; divu 9/0 → LO=0xFFFFFFFF, HI=9, same latency; start pulsed again mid-RUN → no effect.
- rst asserted at RUN step 10 → next cycle busy=0, done=0, HI=LO=0, ALUOut=0; new start accepted immediately after.
- Build without `MC_ALU_MULDIV_EN`: start with multu → busy/done stay 0, HI/LO 0; add/sub/logic results unchanged.

Source files
------------

// File: rtl/mc_alu_md.sv
// Execute-stage ALU: operand muxing, single-cycle ops, registered ALUOut, plus
// an iterative multu/divu engine with HI/LO (present when MC_ALU_MULDIV_EN is defined).
module mc_alu_md #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ALUOp,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    input  logic [IMM_W-1:0] IR_low16,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] ALUOut,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_out_q;
    logic [WIDTH-1:0] hi_v;
    logic [WIDTH-1:0] lo_v;

    assign imm_sext = {{(WIDTH - IMM_W){IR_low16[IMM_W-1]}}, IR_low16};

    always_comb begin
        a_op = ALUSrcA ? regA : PC;
        b_op = regB;
        case (ALUSrcB)
            2'b00:   b_op = regB;
            2'b01:   b_op = WIDTH'(4);
            2'b10:   b_op = imm_sext;
            default: b_op = {imm_sext[WIDTH-3:0], 2'b00};
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (ALUOp)
            2'b00: alu_res = a_op + b_op;
            2'b01: alu_res = a_op - b_op;
            2'b10: begin
                case (funct)
                    F_ADD:   alu_res = a_op + b_op;
                    F_SUB:   alu_res = a_op - b_op;
                    F_AND:   alu_res = a_op & b_op;
                    F_OR:    alu_res = a_op | b_op;
                    F_XOR:   alu_res = a_op ^ b_op;
                    F_NOR:   alu_res = ~(a_op | b_op);
                    F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
`ifdef MC_ALU_MULDIV_EN
                    F_MFHI:  alu_res = hi_v;
                    F_MFLO:  alu_res = lo_v;
`endif
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    assign result = alu_res;
    assign zero   = (alu_res == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_res;
        end
    end

    assign ALUOut = alu_out_q;

`ifdef MC_ALU_MULDIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    md_state_t        state_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] wh_q;
    logic [WIDTH-1:0] wl_q;
    logic [WIDTH-1:0] b_q;
    logic             op_div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] wh_d;
    logic [WIDTH-1:0] wl_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic             md_req;

    assign md_req = start && (ALUOp == 2'b10) && ((funct == F_MULTU) || (funct == F_DIVU));

    // wh/wl hold {partial product high, multiplier} for multu and
    // {partial remainder, dividend/quotient} for divu.
    always_comb begin
        mul_sum  = {1'b0, wh_q} + (wl_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_sh   = {wh_q, wl_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_diff = div_sh[WIDTH-1:0] - b_q;
        wh_d     = mul_sum[WIDTH:1];
        wl_d     = {mul_sum[0], wl_q[WIDTH-1:1]};
        if (op_div_q) begin
            // divisor 0 always "fits": quotient saturates to all ones, remainder ends as A
            wh_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
            wl_d = {wl_q[WIDTH-2:0], div_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            wh_q     <= '0;
            wl_q     <= '0;
            b_q      <= '0;
            op_div_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (md_req) begin
                        wh_q     <= '0;
                        wl_q     <= a_op;
                        b_q      <= b_op;
                        op_div_q <= (funct == F_DIVU);
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    wh_q  <= wh_d;
                    wl_q  <= wl_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        hi_q    <= wh_d;
                        lo_q    <= wl_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hi_v = hi_q;
    assign lo_v = lo_q;
    assign busy = busy_q;
    assign done = done_q;
`else
    logic unused_start;

    assign unused_start = start;
    assign hi_v = '0;
    assign lo_v = '0;
    assign busy = 1'b0;
    assign done = 1'b0;
`endif

    assign HI = hi_v;
    assign LO = lo_v;

endmodule

// File: tb/tb_mc_alu_md.sv
// Directed bench for mc_alu_md: vector table for single-cycle ops, hand sequences for mul/div.
module tb_mc_alu_md;

    logic        clk;
    logic        rst;
    logic [1:0]  ALUOp;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [5:0]  funct;
    logic [31:0] PC, regA, regB;
    logic [15:0] IR_low16;
    logic        start;
    logic [31:0] result, ALUOut, HI, LO;
    logic        zero, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    mc_alu_md #(.WIDTH(32), .IMM_W(16)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .funct(funct), .PC(PC), .regA(regA), .regB(regB), .IR_low16(IR_low16),
        .start(start), .result(result), .zero(zero), .ALUOut(ALUOut),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        sa;
        logic [1:0]  sb;
        logic [5:0]  fn;
        logic [31:0] pc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [15:0] imm;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic sa, input logic [1:0] sb,
                         input logic [5:0] fn, input logic [31:0] ra, input logic [31:0] rb);
        ALUOp = op; ALUSrcA = sa; ALUSrcB = sb; funct = fn; regA = ra; regB = rb;
    endtask

`ifdef MC_ALU_MULDIV_EN
    // Caller is at a negedge; start is presented for exactly one accepting edge.
    task automatic run_md(input string nm, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit pulse_mid);
        drive(2'b10, 1'b1, 2'b00, fn, a, b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        regA = 32'hDEAD_BEEF;
        regB = 32'h1234_5678;
        for (int k = 1; k <= 32; k++) begin
            chk({nm, " busy window"}, {30'd0, busy, done}, 32'd2);
            if (pulse_mid && k == 5) start = 1'b1;
            if (pulse_mid && k == 6) start = 1'b0;
            @(negedge clk);
        end
        chk({nm, " done pulse"}, {30'd0, busy, done}, 32'd1);
        chk({nm, " HI"}, HI, exp_hi);
        chk({nm, " LO"}, LO, exp_lo);
        @(negedge clk);
        chk({nm, " after done"}, {30'd0, busy, done}, 32'd0);
    endtask
`endif

    initial begin
        vecs.push_back('{"addi neg imm", 2'b00, 1'b1, 2'b10, 6'd0, 32'h0, 32'h10, 32'h0, 16'hFFFC, 32'h0000000C, 1'b0});
        vecs.push_back('{"slt -1<1", 2'b10, 1'b1, 2'b00, 6'b101010, 32'h0, 32'hFFFFFFFF, 32'h1, 16'h0, 32'h1, 1'b0});
        vecs.push_back('{"sub 5-5", 2'b10, 1'b1, 2'b00, 6'b100010, 32'h0, 32'h5, 32'h5, 16'h0, 32'h0, 1'b1});
        vecs.push_back('{"pc+4", 2'b00, 1'b0, 2'b01, 6'd0, 32'h100, 32'h7, 32'h9, 16'h0, 32'h00000104, 1'b0});
        vecs.push_back('{"imm<<2", 2'b00, 1'b1, 2'b11, 6'd0, 32'h0, 32'h1000, 32'h0, 16'h8001, 32'hFFFE1004, 1'b0});
        vecs.push_back('{"and", 2'b10, 1'b1, 2'b00, 6'b100100, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0, 32'h00F000F0, 1'b0});
        vecs.push_back('{"or", 2'b10, 1'b1, 2'b00, 6'b100101, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0, 32'hFFF0FFF0, 1'b0});
        vecs.push_back('{"xor", 2'b10, 1'b1, 2'b00, 6'b100110, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0, 32'hFF00FF00, 1'b0});
        vecs.push_back('{"nor", 2'b10, 1'b1, 2'b00, 6'b100111, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0, 32'h000F000F, 1'b0});
        vecs.push_back('{"slt 1<-1", 2'b10, 1'b1, 2'b00, 6'b101010, 32'h0, 32'h1, 32'hFFFFFFFF, 16'h0, 32'h0, 1'b1});
        vecs.push_back('{"add wrap", 2'b10, 1'b1, 2'b00, 6'b100000, 32'h0, 32'hFFFFFFFF, 32'h1, 16'h0, 32'h0, 1'b1});
        vecs.push_back('{"aluop 11", 2'b11, 1'b1, 2'b00, 6'b100000, 32'h0, 32'h5, 32'h3, 16'h0, 32'h0, 1'b1});
        vecs.push_back('{"bad funct", 2'b10, 1'b1, 2'b00, 6'b000000, 32'h0, 32'h5, 32'h3, 16'h0, 32'h0, 1'b1});
        vecs.push_back('{"sub 3-5", 2'b01, 1'b1, 2'b00, 6'd0, 32'h0, 32'h3, 32'h5, 16'h0, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{"mfhi reset", 2'b10, 1'b1, 2'b00, 6'b010000, 32'h0, 32'h5, 32'h3, 16'h0, 32'h0, 1'b1});

        rst = 1'b1; start = 1'b0; PC = 32'h0; IR_low16 = 16'h0;
        drive(2'b00, 1'b1, 2'b00, 6'd0, 32'h11, 32'h22);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ALUOut", ALUOut, 32'h0);
        chk("reset busy/done", {30'd0, busy, done}, 32'd0);
        chk("reset HI", HI, 32'h0);
        chk("reset LO", LO, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].sa, vecs[i].sb, vecs[i].fn, vecs[i].ra, vecs[i].rb);
            PC = vecs[i].pc;
            IR_low16 = vecs[i].imm;
            #1;
            chk({vecs[i].name, " result"}, result, vecs[i].exp_res);
            chk({vecs[i].name, " zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_zero});
            @(posedge clk);
            #1;
            chk({vecs[i].name, " ALUOut"}, ALUOut, vecs[i].exp_res);
        end

        @(negedge clk);
`ifdef MC_ALU_MULDIV_EN
        run_md("multu", 6'b011001, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 1'b0);
        drive(2'b10, 1'b1, 2'b00, 6'b010010, 32'h0, 32'h0);
        #1 chk("mflo", result, 32'hFFFFFFFE);
        drive(2'b10, 1'b1, 2'b00, 6'b010000, 32'h0, 32'h0);
        #1 chk("mfhi", result, 32'h1);
        @(negedge clk);
        run_md("divu 100/7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        run_md("divu 9/0", 6'b011011, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1);

        // abort a multiply partway through RUN
        drive(2'b10, 1'b1, 2'b00, 6'b011001, 32'd3, 32'd4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive(2'b10, 1'b1, 2'b00, 6'b010000, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        #1 chk("mfhi during run", result, 32'd9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy/done", {30'd0, busy, done}, 32'd0);
        chk("abort HI", HI, 32'h0);
        chk("abort LO", LO, 32'h0);
        chk("abort ALUOut", ALUOut, 32'h0);
        run_md("multu after abort", 6'b011001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
`else
        drive(2'b10, 1'b1, 2'b00, 6'b011001, 32'hFFFFFFFF, 32'h2);
        start = 1'b1;
        #1 chk("multu funct result", result, 32'h0);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("nomd busy/done", {30'd0, busy, done}, 32'd0);
        end
        chk("nomd HI", HI, 32'h0);
        chk("nomd LO", LO, 32'h0);
        drive(2'b10, 1'b1, 2'b00, 6'b010010, 32'h7, 32'h7);
        #1 chk("nomd mflo", result, 32'h0);
        drive(2'b10, 1'b1, 2'b00, 6'b100000, 32'h7, 32'h9);
        #1 chk("nomd add", result, 32'h10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
